// File: rtl/datapath_seq_if.sv
// Operation / result bus of the self-sequencing datapath.
// master: the op producer (instruction FSM or bench) drives the op fields and dbg_num.
// slave:  datapath_seq, which drives op_ready, res_valid, result, status and dbg_data.
interface datapath_seq_if #(
   parameter int W   = 16,
   parameter int AW  = 3,
   parameter int PCW = 8
);
   logic           op_valid;
   logic           op_ready;
   logic [AW-1:0]  rn;
   logic [AW-1:0]  rm;
   logic [AW-1:0]  rd;
   logic [1:0]     shift;
   logic [1:0]     alu_op;
   logic           a_zero;
   logic           b_imm;
   logic [W-1:0]   imm;
   logic [1:0]     wb_sel;
   logic           wr_en;
   logic [PCW-1:0] pc;
   logic [W-1:0]   mdata;
   logic           res_valid;
   logic [W-1:0]   result;
   logic [2:0]     status;
   logic [AW-1:0]  dbg_num;
   logic [W-1:0]   dbg_data;

   modport master (
      output op_valid, rn, rm, rd, shift, alu_op, a_zero, b_imm, imm,
             wb_sel, wr_en, pc, mdata, dbg_num,
      input  op_ready, res_valid, result, status, dbg_data
   );

   modport slave (
      input  op_valid, rn, rm, rd, shift, alu_op, a_zero, b_imm, imm,
             wb_sel, wr_en, pc, mdata, dbg_num,
      output op_ready, res_valid, result, status, dbg_data
   );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, shifter, ALU and {V,N,Z} status behind an op handshake.
// Latency: accept edge -> READ -> EXEC -> WB; res_valid/result appear 3 cycles after accept.
// Backpressure: op_ready is high only in IDLE; an op offered while busy waits until it is accepted.
// Ports: clk, reset (async, active-high); bus (slave modport) carries op fields, pc, mdata,
//        op_valid/op_ready, res_valid, result, status and the combinational debug read port.
module datapath_seq #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int PCW  = 8
) (
   input  logic         clk,
   input  logic         reset,
   datapath_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   // Everything the sequence needs is captured at accept, so the producer may change
   // the bus freely while the op is in flight.
   typedef struct packed {
      logic [AW-1:0]  rn;
      logic [AW-1:0]  rm;
      logic [AW-1:0]  rd;
      logic [1:0]     shift;
      logic [1:0]     alu_op;
      logic           a_zero;
      logic           b_imm;
      logic [W-1:0]   imm;
      logic [1:0]     wb_sel;
      logic           wr_en;
      logic [PCW-1:0] pc;
      logic [W-1:0]   mdata;
   } op_t;

   state_t         state;
   state_t         state_nxt;
   logic           accept;
   op_t            op_q;

   logic [W-1:0]   regs [NREG];
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   c_q;
   logic [2:0]     status_q;
   logic [W-1:0]   result_q;
   logic           res_valid_q;

   logic [W-1:0]   b_shift;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic [W-1:0]   alu;
   logic           alu_v;
   logic [W-1:0]   pc_ext;
   logic [W-1:0]   wb_val;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            accept = bus.op_valid;
            if (bus.op_valid) state_nxt = S_READ;
         end
         S_READ:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      b_shift = b_q;
      case (op_q.shift)
         2'b01:   b_shift = {b_q[W-2:0], 1'b0};
         2'b10:   b_shift = {1'b0, b_q[W-1:1]};
         2'b11:   b_shift = {b_q[W-1], b_q[W-1:1]};
         default: b_shift = b_q;
      endcase
   end

   assign a_in = op_q.a_zero ? '0 : a_q;
   assign b_in = op_q.b_imm ? op_q.imm : b_shift;

   // Signed overflow: for ADD the operands share a sign the result lacks; for SUB the
   // operands differ in sign and the result's sign differs from A.
   always_comb begin
      alu   = '0;
      alu_v = 1'b0;
      case (op_q.alu_op)
         2'b00: begin
            alu   = a_in + b_in;
            alu_v = (a_in[W-1] == b_in[W-1]) && (alu[W-1] != a_in[W-1]);
         end
         2'b01: begin
            alu   = a_in - b_in;
            alu_v = (a_in[W-1] != b_in[W-1]) && (alu[W-1] != a_in[W-1]);
         end
         2'b10:   alu = a_in & b_in;
         default: alu = ~b_in;
      endcase
   end

   always_comb begin
      pc_ext            = '0;
      pc_ext[PCW-1:0]   = op_q.pc;
   end

   always_comb begin
      wb_val = c_q;
      case (op_q.wb_sel)
         2'b01:   wb_val = op_q.imm;
         2'b10:   wb_val = pc_ext;
         2'b11:   wb_val = op_q.mdata;
         default: wb_val = c_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         status_q    <= '0;
         result_q    <= '0;
         res_valid_q <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // Pulse marks the edge that completed WB, so result is already valid alongside it.
         res_valid_q <= (state == S_WB);
         if (accept) op_q <= op_t'{bus.rn, bus.rm, bus.rd, bus.shift, bus.alu_op,
                                    bus.a_zero, bus.b_imm, bus.imm, bus.wb_sel,
                                    bus.wr_en, bus.pc, bus.mdata};
         case (state)
            S_READ: begin
               a_q <= regs[op_q.rn];
               b_q <= regs[op_q.rm];
            end
            S_EXEC: begin
               c_q <= alu;
               // Flags only track ALU writebacks; loads of imm/pc/mdata leave them alone.
               if (op_q.wb_sel == 2'b00)
                  status_q <= {alu_v, alu[W-1], (alu == '0)};
            end
            S_WB: begin
               result_q <= wb_val;
               if (op_q.wr_en) regs[op_q.rd] <= wb_val;
            end
            default: ;
         endcase
      end
   end

   assign bus.op_ready  = (state == S_IDLE);
   assign bus.res_valid = res_valid_q;
   assign bus.result    = result_q;
   assign bus.status    = status_q;
   assign bus.dbg_data  = regs[bus.dbg_num];

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed scenarios plus random ops against a behavioural model
// that computes results from plain integer arithmetic on a register array.
module tb_datapath_seq;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   datapath_seq_if #(.W(16), .AW(3), .PCW(8)) bus ();

   datapath_seq #(.W(16), .NREG(8), .AW(3), .PCW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- model
   int mr [8];
   int mst;
   int mres;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mr[i] = 0;
      mst  = 0;
      mres = 0;
   endtask

   task automatic model_op(input int rn, rm, rd, sh, alu, az, bi, imm, wb, we, pc, md);
      int a, b, bb, sa, sb, full, c, v, val;
      a  = az ? 0 : mr[rn];
      bb = mr[rm];
      case (sh)
         1:       bb = (bb * 2) % 65536;
         2:       bb = bb / 2;
         3:       bb = bb / 2 + (bb >= 32768 ? 32768 : 0);
         default: ;
      endcase
      b  = bi ? imm : bb;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      v  = 0;
      case (alu)
         0: begin full = sa + sb; c = (a + b) % 65536; v = (full > 32767 || full < -32768); end
         1: begin full = sa - sb; c = (a - b + 65536) % 65536; v = (full > 32767 || full < -32768); end
         2: c = a & b;
         default: c = 65535 - b;
      endcase
      if (wb == 0) mst = v * 4 + (c >= 32768 ? 2 : 0) + (c == 0 ? 1 : 0);
      case (wb)
         0:       val = c;
         1:       val = imm;
         2:       val = pc;
         default: val = md;
      endcase
      if (we != 0) mr[rd] = val;
      mres = val;
   endtask

   // --------------------------------------------------------------- checks
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input int idx, input int exp);
      bus.dbg_num = 3'(idx);
      #1;
      chk($sformatf("dbg_R%0d", idx), 32'(bus.dbg_data), 32'(exp));
   endtask

   task automatic chk_all_regs();
      for (int i = 0; i < 8; i++) chk_reg(i, mr[i]);
   endtask

   task automatic drive(input int rn, rm, rd, sh, alu, az, bi, imm, wb, we, pc, md);
      bus.rn     = 3'(rn);
      bus.rm     = 3'(rm);
      bus.rd     = 3'(rd);
      bus.shift  = 2'(sh);
      bus.alu_op = 2'(alu);
      bus.a_zero = 1'(az);
      bus.b_imm  = 1'(bi);
      bus.imm    = 16'(imm);
      bus.wb_sel = 2'(wb);
      bus.wr_en  = 1'(we);
      bus.pc     = 8'(pc);
      bus.mdata  = 16'(md);
   endtask

   // Called on the negedge right after the accept edge; returns there when res_valid seen.
   task automatic wait_res(output int lat);
      lat = 0;
      while (!bus.res_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input int rn, rm, rd, sh, alu, az, bi, imm, wb, we, pc, md);
      int k, lat;
      @(negedge clk);
      drive(rn, rm, rd, sh, alu, az, bi, imm, wb, we, pc, md);
      bus.op_valid = 1'b1;
      k = 0;
      while (!bus.op_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("accept_ready", 32'(bus.op_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom);
      wait_res(lat);
      model_op(rn, rm, rd, sh, alu, az, bi, imm, wb, we, pc, md);
      chk("latency", 32'(lat), 32'd3);
      chk("result", 32'(bus.result), 32'(mres));
      chk("status", 32'(bus.status), 32'(mst));
      chk("ready_after_wb", 32'(bus.op_ready), 32'd1);
      @(negedge clk);
      chk("res_valid_pulse", 32'(bus.res_valid), 32'd0);
      chk_all_regs();
   endtask

   // -------------------------------------------------------------- stimulus
   initial begin
      int gap, lat, pulses;
      n_chk  = 0;
      n_fail = 0;
      model_reset();
      bus.op_valid = 1'b0;
      bus.dbg_num  = '0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #12;
      chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_status", 32'(bus.status), 32'd0);
      chk_all_regs();
      @(negedge clk);
      reset = 1'b0;

      // 1: reset mid-EXEC after R1 = 7 (status made nonzero first)
      do_op(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      do_op(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_status", 32'(bus.status), 32'd1);
      @(negedge clk);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      bus.op_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_op_ready", 32'(bus.op_ready), 32'd1);
      chk("midrst_status", 32'(bus.status), 32'd0);
      chk("midrst_result", 32'(bus.result), 32'd0);
      chk_reg(1, 0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.res_valid) pulses++;
      end
      chk("midrst_no_pulse", 32'(pulses), 32'd0);
      chk_reg(1, 0);

      // 2: imm writeback, status unchanged
      do_op(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      do_op(0, 0, 1, 0, 0, 0, 0, 16'h0005, 1, 1, 0, 0);
      chk_reg(1, 16'h0005);
      chk("imm_status_kept", 32'(bus.status), 32'd1);

      // 3: 0x7FFF + 1 -> 0x8000, {V,N,Z} = 110
      do_op(0, 0, 1, 0, 0, 0, 0, 16'h7FFF, 1, 1, 0, 0);
      do_op(0, 0, 2, 0, 0, 0, 0, 16'h0001, 1, 1, 0, 0);
      do_op(1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk_reg(3, 16'h8000);
      chk("add_ovf_status", 32'(bus.status), 32'b110);

      // 4: compare 5 - 5, no write
      do_op(0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      do_op(0, 0, 2, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      do_op(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("cmp_status", 32'(bus.status), 32'b001);
      chk("cmp_result", 32'(bus.result), 32'd0);
      chk_reg(1, 5);

      // 5: ASR then LSR of 0x8002 through the shifter
      do_op(0, 0, 2, 0, 0, 0, 0, 16'h8002, 1, 1, 0, 0);
      do_op(0, 2, 4, 3, 0, 1, 0, 0, 0, 1, 0, 0);
      chk_reg(4, 16'hC001);
      do_op(0, 2, 4, 2, 0, 1, 0, 0, 0, 1, 0, 0);
      chk_reg(4, 16'h4001);

      // 6: back-to-back with op_valid held; second op reads the value just written
      @(negedge clk);
      drive(0, 0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      bus.op_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      drive(1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      gap = 1;
      while (!bus.op_ready && gap < 20) begin
         @(negedge clk);
         gap++;
      end
      chk("b2b_gap", 32'(gap), 32'd4);
      chk("b2b_first_valid", 32'(bus.res_valid), 32'd1);
      chk("b2b_first_result", 32'(bus.result), 32'd9);
      model_op(0, 0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      wait_res(lat);
      model_op(1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      chk("b2b_latency", 32'(lat), 32'd3);
      chk("b2b_result", 32'(bus.result), 32'd9);
      @(negedge clk);
      chk_reg(2, 9);

      // Other sources and ALU ops
      do_op(0, 0, 5, 0, 0, 0, 0, 0, 2, 1, 8'hA7, 0);
      do_op(0, 0, 6, 0, 0, 0, 0, 0, 3, 1, 0, 16'hBEEF);
      do_op(5, 6, 7, 1, 2, 0, 0, 0, 0, 1, 0, 0);
      do_op(0, 6, 7, 0, 3, 0, 0, 0, 0, 1, 0, 0);
      do_op(3, 3, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0);

      // Random ops against the model
      for (int t = 0; t < 40; t++) begin
         int imm;
         case ($urandom_range(0, 3))
            0:       imm = 16'h7FFF;
            1:       imm = 16'h8000;
            default: imm = int'($urandom_range(0, 65535));
         endcase
         do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), imm, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 65535)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
